pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS32 pipeline (pc, if_id, id_ex, ex_mem, mem_wb registers).
- Merges stall requests from ID, EX and MEM into one per-stage stall vector.
- Sequences exception/eret flushes and supplies the redirect PC.
- Runs a MEM bus-wait watchdog and a free-running stall-cycle performance counter.

Parameters:
EXC_VECTOR, 32'h0000_0020, exception handler entry address.
FLUSH_CYCLES, 1, cycles flush is held high per redirect (1..7).
TIMEOUT_CYCLES, 16, consecutive MEM stall cycles that raise a bus timeout (2..255).

Ports:
clk  in  1  pipeline clock, all state updates on posedge.
rst  in  1  synchronous reset, active low (rst == `RESETABLE, i.e. 0).
stallreq_id  in  1  load-use hazard stall request from ID.
stallreq_ex  in  1  multi-cycle op (div/madd) stall request from EX.
stallreq_mem  in  1  data bus not ready, stall request from MEM.
exc_valid  in  1  exception committed in MEM this cycle.
exc_eret  in  1  qualifies exc_valid: eret, redirect to cp0_epc.
cp0_epc  in  `RegBus  EPC value from CP0.
stall  out  6  per-stage hold: [0]pc [1]if [2]id [3]ex [4]mem [5]wb.
flush  out  1  clear all pipeline registers to NOP values.
new_pc  out  `RegBus  redirect address, valid while flush = 1.
bus_timeout  out  1  one-cycle pulse on watchdog expiry.
stall_cycles  out  `RegBus  count of cycles with any stall bit set.

Behaviour:
Reset (rst = 0 at posedge):
- state <= RUN; flush, bus_timeout, new_pc, watchdog count, flush count, stall_cycles all <= 0.
- While rst = 0, stall is forced to 6'b000000 regardless of requests.

FSM states: RUN, FLUSH.

RUN, stall vector (combinational, same cycle, priority MEM > EX > ID):
- stallreq_mem = 1 -> 6'b011111.
- else stallreq_ex = 1 -> 6'b001111.
- else stallreq_id = 1 -> 6'b000111.
- else 6'b000000.
- wb is never stalled.

RUN -> FLUSH on exc_valid = 1 at posedge:
- Registered: flush = 1 from the next cycle.
- new_pc <= cp0_epc if exc_eret = 1, else EXC_VECTOR.
- flush count <= FLUSH_CYCLES - 1.
- In the cycle exc_valid is high, stall is forced to 0. Exception outranks every stall request.

Watchdog (RUN only):
- Counter increments each cycle stallreq_mem = 1 and clears on any cycle stallreq_mem = 0.
- When stallreq_mem = 1 and count = TIMEOUT_CYCLES - 1:
  - bus_timeout = 1 for exactly the next cycle.
  - Enter FLUSH with new_pc <= EXC_VECTOR; counter <= 0.
- Simultaneous exc_valid and expiry: exc_valid wins, including eret target selection. bus_timeout still pulses.

FLUSH:
- flush = 1, stall = 6'b000000, new_pc held constant.
- All stall requests and exc_valid are ignored; the pipeline is being cleared.
- Flush count decrements each cycle. At 0 -> RUN, with flush = 0 in the following cycle.
- Total flush-high duration = FLUSH_CYCLES.
- Watchdog counter is held at 0 throughout.

stall_cycles:
- +1 on every cycle in which the registered-out stall != 0.
- Wraps 32'hFFFF_FFFF -> 0. Not cleared by flush, only by reset.

Reset mid-FLUSH: the next cycle is RUN with flush = 0. No residual pulse.

Latency summary:
- stall: 0 cycles (combinational).
- flush, new_pc, bus_timeout: 1 cycle after the triggering edge.

Decomposition:
- Shared defines package: `RESETABLE, `RegBus, `ZEROWORD; new state encodings `CTRL_RUN / `CTRL_FLUSH; stall masks `STALL_MEM 6'b011111, `STALL_EX 6'b001111, `STALL_ID 6'b000111, `STALL_NONE.
- One sub-module is natural: stall_watchdog (count/clear/expire on stallreq_mem, enable input, expire pulse output).

Test Plan:
1. Reset then idle: rst = 0 for 2 cycles with all requests high -> stall = 0, flush = 0, stall_cycles = 0. Release rst -> stall = 6'b011111 in the same cycle.
2. Priority: stallreq_id = 1 and stallreq_ex = 1 for 3 cycles -> stall = 6'b001111 each cycle; stall_cycles = 3 afterwards.
3. Exception during stall: stallreq_mem = 1 with exc_valid = 1, exc_eret = 0 -> stall = 0 that cycle; next cycle flush = 1 and new_pc = 32'h0000_0020; back to RUN after 1 cycle.
4. Eret with FLUSH_CYCLES = 3, cp0_epc = 32'hBFC0_0100 -> flush high exactly 3 cycles, new_pc = 32'hBFC0_0100 throughout; exc_valid pulse during flush is ignored.
5. Watchdog: stallreq_mem held high 16 cycles -> bus_timeout pulse in cycle 17, flush = 1, new_pc = EXC_VECTOR. Then 15 high, 1 low, 15 high -> no timeout.
6. Counter wrap: preload scenario (force stall_cycles = 32'hFFFF_FFFF), one stalled cycle -> stall_cycles = 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the MIPS32 pipeline stall/flush controller:
// reset polarity, register-bus type, controller state encoding and the
// per-stage stall masks. It also provides a helper that resolves the stall
// requests from ID, EX and MEM into a single stall vector.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Level of rst that holds the controller in reset.
  localparam logic RESETABLE = 1'b0;

  localparam int REG_BUS_W = 32;
  typedef logic [REG_BUS_W-1:0] reg_bus_t;
  localparam reg_bus_t ZEROWORD = '0;

  // Controller FSM encoding.
  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_e;

  // Stall vector bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb.
  // A stalled stage also holds every stage upstream of it. wb never stalls.
  typedef logic [5:0] stall_vec_t;
  localparam stall_vec_t STALL_MEM  = 6'b011111;
  localparam stall_vec_t STALL_EX   = 6'b001111;
  localparam stall_vec_t STALL_ID   = 6'b000111;
  localparam stall_vec_t STALL_NONE = 6'b000000;

  // The oldest requesting stage wins, because its stall mask covers the
  // masks of the younger stages.
  function automatic stall_vec_t stall_mask(input logic req_id,
                                            input logic req_ex,
                                            input logic req_mem);
    stall_vec_t mask;
    if (req_mem)     mask = STALL_MEM;
    else if (req_ex) mask = STALL_EX;
    else if (req_id) mask = STALL_ID;
    else             mask = STALL_NONE;
    return mask;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_stall_watchdog
// This module counts consecutive cycles in which MEM requests a stall. It
// raises o_expire combinationally in the cycle where the count would reach
// TIMEOUT_CYCLES. The count restarts from zero on any cycle without a request,
// on expiry, and whenever i_en is low.
//
// Ports:
//   clk       in   pipeline clock
//   rst       in   synchronous reset, active low
//   i_en      in   count enable (controller is in RUN)
//   i_req     in   MEM stall request (data bus not ready)
//   o_expire  out  high in the cycle the watchdog expires (combinational)
// -----------------------------------------------------------------------------
module pipe_ctrl_stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req,
  output logic o_expire
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;
  logic       w_counting;

  assign w_counting = i_en && i_req;
  assign o_expire   = w_counting && (r_count == LAST_COUNT);

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values, independent of the order in which the processes run.
  always_ff @(posedge clk) begin
    if (rst == RESETABLE) begin
      r_count <= '0;
    end else if (!w_counting || o_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// This is the central stall/flush controller for the 5-stage MIPS32 pipeline.
// It has the following functions:
//   - It merges the stall requests from ID, EX and MEM into one per-stage
//     stall vector. This path is combinational: the stall vector changes in
//     the same cycle as the request.
//   - It sequences the flush for an exception or eret. The flush holds for
//     FLUSH_CYCLES cycles and the module supplies the redirect PC.
//   - It runs a MEM bus-wait watchdog. On expiry the watchdog pulses
//     bus_timeout and forces a flush to EXC_VECTOR.
//   - It keeps a free-running count of the cycles in which any stage is
//     stalled. Only reset clears this count.
//
// Ports:
//   clk           in   pipeline clock
//   rst           in   synchronous reset, active low
//   stallreq_id   in   load-use hazard stall request from ID
//   stallreq_ex   in   multi-cycle op stall request from EX
//   stallreq_mem  in   data bus not ready, stall request from MEM
//   exc_valid     in   exception committed in MEM this cycle
//   exc_eret      in   qualifies exc_valid: eret, redirect to cp0_epc
//   cp0_epc       in   EPC value from CP0
//   stall         out  per-stage hold [0]pc [1]if [2]id [3]ex [4]mem [5]wb
//   flush         out  clear all pipeline registers to NOP values
//   new_pc        out  redirect address, valid while flush = 1
//   bus_timeout   out  one-cycle pulse on watchdog expiry
//   stall_cycles  out  count of cycles with any stall bit set
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int          FLUSH_CYCLES   = 1,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic        exc_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  ctrl_state_e r_state;
  ctrl_state_e w_state_next;
  logic [2:0]  r_flush_cnt;
  reg_bus_t    r_new_pc;
  logic        r_bus_timeout;
  reg_bus_t    r_stall_cycles;
  stall_vec_t  w_stall;
  logic        w_expire;
  logic        w_in_run;

  assign w_in_run = (r_state == CTRL_RUN);

  pipe_ctrl_stall_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_in_run),
    .i_req    (stallreq_mem),
    .o_expire (w_expire)
  );

  // Next state and stall vector.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_stall      = STALL_NONE;
    case (r_state)
      CTRL_RUN: begin
        if (exc_valid || w_expire) w_state_next = CTRL_FLUSH;
        // The pipeline is redirected when an exception commits, so the
        // exception takes priority over every stall request.
        if (!exc_valid) w_stall = stall_mask(stallreq_id, stallreq_ex, stallreq_mem);
      end
      CTRL_FLUSH: begin
        if (r_flush_cnt == 3'd0) w_state_next = CTRL_RUN;
      end
      default: w_state_next = CTRL_RUN;
    endcase
    if (rst == RESETABLE) w_stall = STALL_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst == RESETABLE) begin
      r_state <= CTRL_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush sequencing and redirect target.
  always_ff @(posedge clk) begin
    if (rst == RESETABLE) begin
      r_flush_cnt   <= '0;
      r_new_pc      <= ZEROWORD;
      r_bus_timeout <= 1'b0;
    end else begin
      r_bus_timeout <= w_expire;
      if (w_in_run) begin
        // If an exception and a watchdog expiry occur in the same cycle,
        // the exception selects the target. bus_timeout still pulses.
        if (exc_valid) begin
          r_new_pc    <= exc_eret ? cp0_epc : EXC_VECTOR;
          r_flush_cnt <= FLUSH_INIT;
        end else if (w_expire) begin
          r_new_pc    <= EXC_VECTOR;
          r_flush_cnt <= FLUSH_INIT;
        end
      end else if (r_flush_cnt != 3'd0) begin
        r_flush_cnt <= r_flush_cnt - 3'd1;
      end
    end
  end

  // Performance counter. It wraps silently and a flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst == RESETABLE) begin
      r_stall_cycles <= ZEROWORD;
    end else if (w_stall != STALL_NONE) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall        = w_stall;
  assign flush        = (r_state == CTRL_FLUSH);
  assign new_pc       = r_new_pc;
  assign bus_timeout  = r_bus_timeout;
  assign stall_cycles = r_stall_cycles;

endmodule
